imem_boot: RTL and testbench
============================

IMEM_BOOT -- requirements
Module: imem_boot

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: fetch/write word-address width.
REQ-002 SHALL have parameter DATA_W, default 32: instruction width, a multiple of 8; BPW = DATA_W/8.
REQ-003 SHALL have parameter DEPTH, default 256: words implemented, DEPTH <= 2^ADDR_W.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port fetch_en, input, 1: fetch request this cycle.
REQ-007 SHALL have port fetch_addr, input, ADDR_W: word address of the fetch.
REQ-008 SHALL have port instr, output, DATA_W: fetched instruction, registered.
REQ-009 SHALL have port instr_valid, output, 1: instr holds a fresh fetch result.
REQ-010 SHALL have port load_start, input, 1: begin program load at address 0.
REQ-011 SHALL have port load_byte, input, 8: serial program byte.
REQ-012 SHALL have port load_byte_valid, input, 1: load_byte is valid.
REQ-013 SHALL have port load_byte_ready, output, 1: byte accepted when valid & ready.
REQ-014 SHALL have port load_busy, output, 1: high in LOAD or COMMIT.
REQ-015 SHALL have port load_done, output, 1: one-cycle pulse at the end of a load.
REQ-016 SHALL have port load_count, output, ADDR_W+1: words written by the last load.
REQ-017 SHALL have port fault, output, 1: out-of-range fetch flag, aligned with instr.

Function
REQ-018 SHALL implement FSM states RUN, LOAD, COMMIT.
REQ-019 In RUN with fetch_en=1 and load_start=0, SHALL present RAM[fetch_addr] on instr with instr_valid=1 on the next edge (1-cycle latency).
REQ-020 With fetch_en=0 or state != RUN, SHALL hold instr and drive instr_valid=0 next cycle.
REQ-021 load_start in RUN SHALL take priority over fetch_en: the fetch is dropped, state goes to LOAD, and write pointer, byte count and load_count are cleared.
REQ-022 load_start outside RUN SHALL be ignored.
REQ-023 load_byte_ready SHALL be 1 in LOAD and 0 in RUN and COMMIT.
REQ-024 Each accepted byte SHALL shift into the word assembler MSB-first; the BPW-th byte SHALL move state to COMMIT.
REQ-025 In COMMIT, an all-ones word SHALL be treated as the terminator: it is not written, and state goes to RUN with load_done=1.
REQ-026 In COMMIT, any other word SHALL be written to RAM[wptr], then wptr and load_count increment.
REQ-027 If the written address is DEPTH-1, SHALL go to RUN with load_done=1 and load_count=DEPTH; otherwise SHALL return to LOAD.
REQ-028 load_count SHALL hold its value after load_done until the next load_start.
REQ-029 Memory contents SHALL initialise to all zeros (NOP) at time zero and SHALL NOT be affected by reset.

Reset
REQ-030 On reset, SHALL set state=RUN, instr=0, instr_valid=0, fault=0, load_done=0, load_busy=0, load_count=0, wptr=0, byte count=0.
REQ-031 Reset mid-load SHALL discard the partial word and retain words already committed.

Configuration
REQ-032 With IMEM_BOUNDS_CHECK_EN defined, a RUN fetch with fetch_addr >= DEPTH SHALL return instr=0, instr_valid=1, fault=1 for that one result cycle.
REQ-033 Without IMEM_BOUNDS_CHECK_EN, fault SHALL be constant 0, and instr for fetch_addr >= DEPTH is unspecified.

Verification
REQ-034 Reset, then fetch addresses 0..3 back-to-back -> instr=0, instr_valid=1 each cycle after the request, fault=0.
REQ-035 load_start, bytes 20 01 00 48 / 00 00 00 00 / FF FF FF FF -> RAM[0]=0x20010048, RAM[1]=0, load_done pulse, load_count=2; fetch 0 -> 0x20010048.
REQ-036 Hold load_byte_valid=1 continuously -> ready=0 in every COMMIT cycle; no byte lost or duplicated.
REQ-037 DEPTH=4: load 4 words without terminator -> load_done after 4th COMMIT, load_count=4, fetch 3 returns 4th word.
REQ-038 Reset after 2 bytes of word 1 in a load -> RAM[0] keeps its committed value, state=RUN, load_busy=0.
REQ-039 IMEM_BOUNDS_CHECK_EN, DEPTH=16: fetch 20 -> instr=0, fault=1 for one cycle; fetch 5 next -> fault=0.

Source files
------------

// File: rtl/imem_boot.sv
// Boot-loadable instruction memory: a serial byte loader fills the RAM, and the RUN state serves 1-cycle fetches.
// Optional macro IMEM_BOUNDS_CHECK_EN: out-of-range fetches return 0 and raise fault.
module imem_boot #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              load_start,
  input  logic [7:0]        load_byte,
  input  logic              load_byte_valid,
  output logic              load_byte_ready,
  output logic              load_busy,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  output logic              fault
);

  localparam int BPW   = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [1:0] {RUN, LOAD, COMMIT} state_t;
  state_t state_q, state_d;

  // Power-up contents are NOPs; reset deliberately never touches the array.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic [IDX_W-1:0]  wptr;
  logic [CNT_W-1:0]  bcnt;
  logic [DATA_W-1:0] word;
  logic              fetch_go;
  logic              load_go;
  logic              accept;
  logic              commit_wr;
  logic              finish;
  logic              last_byte;
  logic              oob;

  assign last_byte       = (bcnt == CNT_W'(BPW - 1));
  assign load_byte_ready = (state_q == LOAD);
  assign load_busy       = (state_q != RUN);

`ifdef IMEM_BOUNDS_CHECK_EN
  assign oob = ({1'b0, fetch_addr} >= (ADDR_W+1)'(DEPTH));
`else
  assign oob = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    fetch_go  = 1'b0;
    load_go   = 1'b0;
    accept    = 1'b0;
    commit_wr = 1'b0;
    finish    = 1'b0;
    case (state_q)
      RUN: begin
        if (load_start) begin
          load_go = 1'b1;
          state_d = LOAD;
        end else begin
          fetch_go = fetch_en;
        end
      end
      LOAD: begin
        if (load_byte_valid) begin
          accept = 1'b1;
          if (last_byte) state_d = COMMIT;
        end
      end
      COMMIT: begin
        // An all-ones word marks the end of the program image and is never stored.
        if (word == '1) begin
          finish  = 1'b1;
          state_d = RUN;
        end else begin
          commit_wr = 1'b1;
          if (wptr == IDX_W'(DEPTH - 1)) begin
            finish  = 1'b1;
            state_d = RUN;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr       <= '0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
      load_done   <= 1'b0;
      load_count  <= '0;
      wptr        <= '0;
      bcnt        <= '0;
      word        <= '0;
    end else begin
      load_done   <= finish;
      instr_valid <= fetch_go;
      fault       <= fetch_go & oob;
      if (fetch_go) instr <= oob ? '0 : mem[fetch_addr[IDX_W-1:0]];
      if (load_go) begin
        wptr       <= '0;
        bcnt       <= '0;
        load_count <= '0;
      end
      // Bytes arrive most-significant first, so older bytes shift toward the MSB.
      if (accept) begin
        word <= (word << 8) | DATA_W'(load_byte);
        bcnt <= last_byte ? '0 : bcnt + 1'b1;
      end
      if (commit_wr) begin
        wptr       <= wptr + 1'b1;
        load_count <= load_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit_wr && !reset) mem[wptr] <= word;
  end

endmodule

// File: tb/tb_imem_boot.sv
// Randomized scoreboard bench for imem_boot (DEPTH=16); honours IMEM_BOUNDS_CHECK_EN when defined.
module tb_imem_boot;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int BPW    = DATA_W / 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              fetch_en = 1'b0;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              load_start = 1'b0;
  logic [7:0]        load_byte = '0;
  logic              load_byte_valid = 1'b0;
  logic              load_byte_ready;
  logic              load_busy;
  logic              load_done;
  logic [ADDR_W:0]   load_count;
  logic              fault;

  imem_boot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
    .instr(instr), .instr_valid(instr_valid), .load_start(load_start),
    .load_byte(load_byte), .load_byte_valid(load_byte_valid),
    .load_byte_ready(load_byte_ready), .load_busy(load_busy),
    .load_done(load_done), .load_count(load_count), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] instr;
    logic              fault;
    bit                chk;
  } fexp_t;

  fexp_t             fq[$];
  int                doneq[$];
  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [7:0]        prog[$];
  logic [DATA_W-1:0] exp_hold;
  bit                hold_known;
  int                last_count;
  bit                prev_done;
  fexp_t             mon_e;
  int                n_checks = 0;
  int                n_fail = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented fetch result is matched against the oldest expectation.
  always @(negedge clk) begin
    if (reset) begin
      prev_done = 1'b0;
    end else begin
      if (instr_valid) begin
        if (fq.size() == 0) begin
          checkOutput("unexpected_valid", instr_valid, 1'b0);
        end else begin
          mon_e = fq.pop_front();
          if (mon_e.chk) checkOutput("fetch_instr", instr, mon_e.instr);
          checkOutput("fetch_fault", fault, mon_e.fault);
          exp_hold   = mon_e.instr;
          hold_known = mon_e.chk;
        end
      end else begin
        if (hold_known) checkOutput("instr_hold", instr, exp_hold);
        checkOutput("fault_idle", fault, 1'b0);
      end
      if (load_done) begin
        checkOutput("done_pulse_width", prev_done, 1'b0);
        if (doneq.size() == 0) checkOutput("unexpected_done", load_done, 1'b0);
        else checkOutput("load_count_at_done", load_count, doneq.pop_front());
        checkOutput("busy_at_done", load_busy, 1'b0);
      end
      prev_done = load_done;
    end
  end

  task automatic pushExp(input int a);
    fexp_t e;
    if (a < DEPTH) begin
      e.instr = model_mem[a]; e.fault = 1'b0; e.chk = 1'b1;
    end else begin
`ifdef IMEM_BOUNDS_CHECK_EN
      e.instr = '0; e.fault = 1'b1; e.chk = 1'b1;
`else
      e.instr = '0; e.fault = 1'b0; e.chk = 1'b0;
`endif
    end
    fq.push_back(e);
  endtask

  task automatic fetchOne(input int a);
    fetch_en   = 1'b1;
    fetch_addr = ADDR_W'(a);
    pushExp(a);
    @(negedge clk);
    fetch_en = 1'b0;
  endtask

  task automatic idle(input int n);
    fetch_en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b1;
    fetch_en = 1'b0; load_start = 1'b0; load_byte_valid = 1'b0;
    fq.delete();
    doneq.delete();
    repeat (2) @(negedge clk);
    exp_hold = '0; hold_known = 1'b1; last_count = 0;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_instr", instr, '0);
    checkOutput("rst_valid", instr_valid, 1'b0);
    checkOutput("rst_fault", fault, 1'b0);
    checkOutput("rst_done", load_done, 1'b0);
    checkOutput("rst_busy", load_busy, 1'b0);
    checkOutput("rst_count", load_count, '0);
    checkOutput("rst_ready", load_byte_ready, 1'b0);
  endtask

  task automatic buildProg(input int nwords, input bit term);
    logic [DATA_W-1:0] v;
    prog.delete();
    for (int w = 0; w < nwords; w++) begin
      v = $urandom;
      if (v == '1) v = '0;
      for (int b = BPW - 1; b >= 0; b--) prog.push_back(v[b*8 +: 8]);
    end
    if (term) for (int b = 0; b < BPW; b++) prog.push_back(8'hFF);
  endtask

  // Feed prog to the loader; the model walks it word by word to find what gets stored.
  task automatic doLoad(input bit cont, input bit fetch_at_start, input bit poke_start);
    logic [DATA_W-1:0] v;
    int nbytes, nw, budget;
    bit ended;
    nbytes = 0; nw = 0; ended = 1'b0;
    for (int w = 0; !ended && (w + 1) * BPW <= prog.size(); w++) begin
      v = '0;
      for (int b = 0; b < BPW; b++) v = (v << 8) | DATA_W'(prog[w*BPW + b]);
      nbytes += BPW;
      if (v == '1) ended = 1'b1;
      else begin
        model_mem[w] = v;
        nw++;
        if (w == DEPTH - 1) ended = 1'b1;
      end
    end
    doneq.push_back(nw);
    last_count = nw;

    load_start = 1'b1;
    fetch_en   = fetch_at_start;
    fetch_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
    @(negedge clk);
    load_start = 1'b0;
    fetch_en   = 1'b0;
    checkOutput("ready_in_load", load_byte_ready, 1'b1);
    checkOutput("count_cleared", load_count, '0);

    for (int i = 0; i < nbytes; i++) begin
      if (!cont && $urandom_range(0, 3) == 0) begin
        load_byte_valid = 1'b0;
        load_byte = 8'($urandom);
        @(negedge clk);
      end
      load_byte_valid = 1'b1;
      load_byte  = prog[i];
      load_start = poke_start && (i == nbytes / 2);
      fetch_en   = 1'($urandom_range(0, 1));
      fetch_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      budget = 20;
      while (!load_byte_ready && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (!load_byte_ready) begin
        checkOutput("byte_accept_timeout", load_byte_ready, 1'b1);
        break;
      end
      @(negedge clk);
      load_start = 1'b0;
    end
    load_byte_valid = 1'b0;
    fetch_en = 1'b0;
    budget = 10;
    while (load_busy && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput("load_finish", load_busy, 1'b0);
    @(negedge clk);
    checkOutput("done_consumed", doneq.size(), 0);
    idle(1);
  endtask

  task automatic doResetMidLoad();
    logic [DATA_W-1:0] w0;
    int budget;
    w0 = $urandom;
    if (w0 == '1) w0 = '0;
    prog.delete();
    for (int b = BPW - 1; b >= 0; b--) prog.push_back(w0[b*8 +: 8]);
    prog.push_back(8'hA5);
    prog.push_back(8'h5A);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < prog.size(); i++) begin
      load_byte_valid = 1'b1;
      load_byte = prog[i];
      budget = 20;
      while (!load_byte_ready && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (!load_byte_ready) begin
        checkOutput("midload_timeout", load_byte_ready, 1'b1);
        break;
      end
      @(negedge clk);
    end
    load_byte_valid = 1'b0;
    model_mem[0] = w0;
    doReset();
    fetchOne(0);
    fetchOne(1);
    idle(2);
  endtask

  task automatic applyStimulus(input int kind);
    int n;
    case (kind)
      0, 1: begin
        checkOutput("load_count_hold", load_count, last_count);
        n = $urandom_range(1, 12);
        for (int i = 0; i < n; i++) begin
          if ($urandom_range(0, 3) != 0) fetchOne($urandom_range(0, DEPTH + 7));
          else idle(1);
        end
        idle(2);
      end
      2: begin
        n = $urandom_range(0, DEPTH + 2);
        buildProg(n, (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1)));
        doLoad(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      default: doResetMidLoad();
    endcase
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    foreach (model_mem[i]) model_mem[i] = '0;
    exp_hold = '0;
    hold_known = 1'b1;
    last_count = 0;
    doReset();

    for (int a = 0; a < 4; a++) fetchOne(a);
    idle(2);

    prog = '{8'h20, 8'h01, 8'h00, 8'h48, 8'h00, 8'h00, 8'h00, 8'h00,
             8'hFF, 8'hFF, 8'hFF, 8'hFF};
    doLoad(1'b0, 1'b1, 1'b0);
    fetchOne(0);
    fetchOne(1);
    idle(2);
    checkOutput("directed_word0", model_mem[0], 32'h20010048);

    buildProg(DEPTH, 1'b0);
    doLoad(1'b1, 1'b0, 1'b1);
    fetchOne(DEPTH - 1);
    fetchOne(0);
    idle(2);

    doResetMidLoad();

    fetchOne(20);
    fetchOne(5);
    idle(2);

    for (int it = 0; it < 40; it++) applyStimulus(($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, 2));

    idle(3);
    checkOutput("fetch_queue_drained", fq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
